// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter with
// bounded ownership time.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // First set request bit searching ptr, ptr+1, ... (mod N_REQ).
  // Walking the offsets downward lets the smallest offset win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter4_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (output req, input grant, grant_idx, grant_valid, timeout);
  modport slave  (input req, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/onehot_dec2.sv
// 2-bit index to 4-bit one-hot decoder with enable; output is zero when disabled.
module onehot_dec2
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  assign onehot_o = en_i ? (N_REQ'(1) << idx_i) : '0;

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters: one-cycle grant latency, ownership
// capped at MAX_HOLD cycles, and one forced idle cycle after every release.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;
  logic [IDX_W-1:0] pick_idx;

  assign pick_idx = rr_pick(bus.req, ptr_q);

  // NOTE: every register in this block uses non-blocking assignment so all
  // branches read the pre-edge values of state_q, grant_idx_q and hold_cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q     <= OWN;
            grant_idx_q <= pick_idx;
            hold_cnt_q  <= '0;
          end
        end
        OWN: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          // A dropped request wins over the hold limit, so no timeout then.
          if (!bus.req[grant_idx_q]) begin
            state_q     <= GAP;
            ptr_q       <= grant_idx_q + 1'b1;
            grant_idx_q <= '0;
            hold_cnt_q  <= '0;
          end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            state_q     <= GAP;
            ptr_q       <= grant_idx_q + 1'b1;
            grant_idx_q <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b1;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  onehot_dec2 u_grant_dec (
    .idx_i    (grant_idx_q),
    .en_i     (state_q == OWN),
    .onehot_o (bus.grant)
  );

  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = (state_q == OWN);
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed-vector bench for rr_arbiter4 with MAX_HOLD = 4; outputs are sampled
// on the falling edge and inputs changed there for the next rising edge.
module tb_rr_arbiter4;
  import rr_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: idx_of = 2'd1;
      4'b0100: idx_of = 2'd2;
      4'b1000: idx_of = 2'd3;
      default: idx_of = 2'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected grant/timeout plus the per-cycle structural invariants.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic to);
    check($sformatf("%s.grant", tag), 32'(bus.grant), 32'(g));
    check($sformatf("%s.idx", tag), 32'(bus.grant_idx), 32'(idx_of(g)));
    check($sformatf("%s.valid", tag), 32'(bus.grant_valid), 32'(|g));
    check($sformatf("%s.timeout", tag), 32'(bus.timeout), 32'(to));
    check($sformatf("%s.onehot0", tag), 32'($onehot0(bus.grant)), 32'd1);
    check($sformatf("%s.valid_or", tag), 32'(bus.grant_valid), 32'(|bus.grant));
    check($sformatf("%s.idx_dec", tag), 32'(bus.grant_idx), 32'(idx_of(bus.grant)));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req  = '0;
    @(negedge clk);
    tick();
    expect_out("reset", 4'b0000, 1'b0);

    // Scenario A: 0101 -> owner 0, released after 2 cycles, then owner 2.
    rst     = 1'b0;
    bus.req = 4'b0101;
    tick(); expect_out("a_own0_c1", 4'b0001, 1'b0);
    tick(); expect_out("a_own0_c2", 4'b0001, 1'b0);
    bus.req = 4'b0100;
    tick(); expect_out("a_gap", 4'b0000, 1'b0);
    tick(); expect_out("a_idle", 4'b0000, 1'b0);
    tick(); expect_out("a_own2", 4'b0100, 1'b0);
    bus.req = 4'b0000;
    tick(); expect_out("a_gap2", 4'b0000, 1'b0);
    tick(); expect_out("a_idle2", 4'b0000, 1'b0);
    tick(); expect_out("a_idle_noreq", 4'b0000, 1'b0);

    // Scenario B: all request continuously, pointer restarted by reset.
    rst = 1'b1;
    tick(); expect_out("b_reset", 4'b0000, 1'b0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick(); expect_out($sformatf("b_own%0d_c%0d", k, c), 4'(1 << k), 1'b0);
      end
      tick(); expect_out($sformatf("b_gap%0d", k), 4'b0000, 1'b1);
      tick(); expect_out($sformatf("b_idle%0d", k), 4'b0000, 1'b0);
    end
    tick(); expect_out("b_wrap_own0", 4'b0001, 1'b0);
    bus.req = 4'b0000;
    tick(); expect_out("b_rel_gap", 4'b0000, 1'b0);
    tick(); expect_out("b_rel_idle", 4'b0000, 1'b0);

    // Scenario C: lone requester 1 times out and is re-granted.
    bus.req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick(); expect_out($sformatf("c_own1_c%0d", c), 4'b0010, 1'b0);
    end
    tick(); expect_out("c_gap_to", 4'b0000, 1'b1);
    tick(); expect_out("c_idle", 4'b0000, 1'b0);
    tick(); expect_out("c_regrant", 4'b0010, 1'b0);
    bus.req = 4'b0000;
    tick(); expect_out("c_rel_gap", 4'b0000, 1'b0);
    tick(); expect_out("c_rel_idle", 4'b0000, 1'b0);

    // Scenario D: owner 2 drops on its final cycle -> release, no timeout.
    bus.req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick(); expect_out($sformatf("d_own2_c%0d", c), 4'b0100, 1'b0);
    end
    bus.req = 4'b1001;
    tick(); expect_out("d_gap_no_to", 4'b0000, 1'b0);
    tick(); expect_out("d_idle", 4'b0000, 1'b0);
    tick(); expect_out("d_own3", 4'b1000, 1'b0);

    // Scenario E: reset during ownership of 3, then arbitration from ptr 0.
    tick(); expect_out("e_own3_c2", 4'b1000, 1'b0);
    rst = 1'b1;
    tick(); expect_out("e_reset", 4'b0000, 1'b0);
    rst = 1'b0;
    tick(); expect_out("e_own0", 4'b0001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
